// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage access sequencer: mem_func codes, FSM states,
// lane widths and the alignment rule.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    MF_BS = 3'd0,
    MF_BU = 3'd1,
    MF_HS = 3'd2,
    MF_HU = 3'd3,
    MF_WD = 3'd4,
    MF_WL = 3'd5,
    MF_WR = 3'd6,
    MF_WC = 3'd7
  } memfunc_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_RMW_WR,
    S_WR,
    S_DONE
  } state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  // WL/WR address the whole word regardless of the low address bits.
  function automatic logic misaligned(input memfunc_e f, input logic [1:0] a);
    logic r;
    r = 1'b0;
    case (f)
      MF_HS, MF_HU: r = a[0];
      MF_WD, MF_WC: r = (a != 2'b00);
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_merge.sv
// Lane logic: extracts the addressed load lane to bit 0 and merges store data
// into a read word for read-modify-write.
module mem_lane_merge
  import mem_access_ctrl_pkg::*;
(
  input  memfunc_e    func_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  assign byte_sh   = {addr_lo_i, 3'b000};
  assign half_sh   = {addr_lo_i[1], 4'b0000};
  assign byte_mask = {{(32-BYTE_W){1'b0}}, {BYTE_W{1'b1}}};
  assign half_mask = {{(32-HALF_W){1'b0}}, {HALF_W{1'b1}}};

  always_comb begin
    load_data_o  = rdata_i;
    merge_data_o = rdata_i;
    case (func_i)
      MF_BS, MF_BU: begin
        load_data_o  = (rdata_i >> byte_sh) & byte_mask;
        merge_data_o = (rdata_i & ~(byte_mask << byte_sh))
                     | ((sdata_i & byte_mask) << byte_sh);
      end
      MF_HS, MF_HU: begin
        load_data_o  = (rdata_i >> half_sh) & half_mask;
        merge_data_o = (rdata_i & ~(half_mask << half_sh))
                     | ((sdata_i & half_mask) << half_sh);
      end
      MF_WL:   merge_data_o = {sdata_i[31:16], rdata_i[15:0]};
      MF_WR:   merge_data_o = {rdata_i[31:16], sdata_i[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: turns one load/store request into word-only memory
// transactions, with read-modify-write for partial stores and an ack timeout.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Req,
  input  logic        Write,
  input  logic [2:0]  Memfunc,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic        Stall,
  output logic        Done,
  output logic        Error,
  output logic [31:0] LoadData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  memfunc_e    func_q, func_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] sdata_q, sdata_d;
  logic        err_q, err_d;
  logic [31:0] load_q, load_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;
  memfunc_e    func_in;

  assign func_in = memfunc_e'(Memfunc);

  mem_lane_merge u_lane (
    .func_i       (func_q),
    .addr_lo_i    (addr_lo_q),
    .rdata_i      (mem_rdata),
    .sdata_i      (sdata_q),
    .load_data_o  (lane_load),
    .merge_data_o (lane_merge)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      func_q    <= MF_BS;
      addr_lo_q <= '0;
      sdata_q   <= '0;
      err_q     <= 1'b0;
      load_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func_q    <= func_d;
      addr_lo_q <= addr_lo_d;
      sdata_q   <= sdata_d;
      err_q     <= err_d;
      load_q    <= load_d;
      req_q     <= req_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func_d    = func_q;
    addr_lo_d = addr_lo_q;
    sdata_d   = sdata_q;
    err_d     = err_q;
    load_d    = load_q;
    req_d     = req_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          func_d    = func_in;
          addr_lo_d = Address[1:0];
          sdata_d   = StoreData;
          maddr_d   = {Address[31:2], 2'b00};
          err_d     = 1'b0;
          cnt_d     = '0;
          if (misaligned(func_in, Address[1:0]) || (Write && func_in == MF_WC)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (!Write) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            state_d = S_RD;
          end else if (func_in == MF_WD) begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            wdata_d = StoreData;
            state_d = S_WR;
          end else begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD, S_RMW_RD, S_RMW_WR, S_WR: begin
        // req_q is low only in the single idle cycle that opens RMW_WR.
        if (!req_q) begin
          req_d = 1'b1;
          we_d  = 1'b1;
        end else if (mem_ack) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          cnt_d = '0;
          if (state_q == S_RD) begin
            load_d  = lane_load;
            state_d = S_DONE;
          end else if (state_q == S_RMW_RD) begin
            wdata_d = lane_merge;
            state_d = S_RMW_WR;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign Done      = (state_q == S_DONE);
  assign Error     = Done & err_q;
  assign Stall     = Req & ~Done;
  assign LoadData  = load_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios followed by random
// accesses, checked against a word-array memory and a request-level model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        Req;
  logic        Write;
  logic [2:0]  Memfunc;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic        Stall;
  logic        Done;
  logic        Error;
  logic [31:0] LoadData;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] mem [0:255];
  logic [31:0] exp_load;

  always #5 clock = ~clock;

  mem_access_ctrl #(.TIMEOUT(TO), .CW(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .Req       (Req),
    .Write     (Write),
    .Memfunc   (Memfunc),
    .Address   (Address),
    .StoreData (StoreData),
    .Stall     (Stall),
    .Done      (Done),
    .Error     (Error),
    .LoadData  (LoadData),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mis(input logic [2:0] f, input logic [1:0] a);
    if (f == 3'(MF_HS) || f == 3'(MF_HU)) return a[0];
    if (f == 3'(MF_WD) || f == 3'(MF_WC)) return a != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [2:0] f, input logic [1:0] a);
    logic [31:0] r;
    int sh;
    r = w;
    if (f == 3'(MF_BS) || f == 3'(MF_BU)) begin
      sh = 8 * int'(a);
      r  = {24'h0, w[sh +: 8]};
    end else if (f == 3'(MF_HS) || f == 3'(MF_HU)) begin
      sh = 16 * int'(a[1]);
      r  = {16'h0, w[sh +: 16]};
    end
    return r;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [31:0] s,
                                          input logic [2:0] f, input logic [1:0] a);
    logic [31:0] r;
    int sh;
    r = w;
    if (f == 3'(MF_BS) || f == 3'(MF_BU)) begin
      sh = 8 * int'(a);
      r[sh +: 8] = s[7:0];
    end else if (f == 3'(MF_HS) || f == 3'(MF_HU)) begin
      sh = 16 * int'(a[1]);
      r[sh +: 16] = s[15:0];
    end else if (f == 3'(MF_WL)) begin
      r[31:16] = s[31:16];
    end else if (f == 3'(MF_WR)) begin
      r[15:0] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] span(input int unsigned a, input int unsigned n);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = a; i < a + n; i++)
      if (i < 64) r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  // One request: the model predicts latency, mem_req trace, error, load result
  // and memory contents; the loop below plays the memory with w1/w2 wait states.
  task automatic access(input logic wr, input logic [2:0] fn, input logic [31:0] ad,
                        input logic [31:0] sd, input int unsigned w1, input int unsigned w2,
                        input logic b2b);
    int unsigned off, exp_done, done_c, c, wcnt, txn, nwr, exp_nwr, bad, cur_w;
    logic [63:0] exp_tr, act_tr;
    logic        exp_err, err_obs, in_txn, seen;
    logic [31:0] old_w, exp_w, exp_ld, t_addr, t_wdata, wr_addr, ld_obs;
    logic        t_we;
    logic [7:0]  idx;

    off = b2b ? 1 : 0;
    idx = ad[9:2];
    old_w = mem[idx];
    exp_w = old_w;
    exp_ld = exp_load;
    exp_tr = '0;
    exp_err = 1'b0;
    exp_nwr = 0;
    if (is_mis(fn, ad[1:0]) || (wr && fn == 3'(MF_WC))) begin
      exp_err = 1'b1;
      exp_done = 1;
    end else if (w1 >= TO) begin
      exp_tr = span(1, TO);
      exp_err = 1'b1;
      exp_done = 1 + TO;
    end else if (!wr || fn == 3'(MF_WD)) begin
      exp_tr = span(1, w1 + 1);
      exp_done = 2 + w1;
      if (!wr) exp_ld = f_load(old_w, fn, ad[1:0]);
      else begin exp_w = sd; exp_nwr = 1; end
    end else begin
      exp_tr = span(1, w1 + 1);
      if (w2 >= TO) begin
        exp_tr = exp_tr | span(3 + w1, TO);
        exp_err = 1'b1;
        exp_done = 3 + w1 + TO;
      end else begin
        exp_tr = exp_tr | span(3 + w1, w2 + 1);
        exp_done = 4 + w1 + w2;
        exp_w = f_merge(old_w, sd, fn, ad[1:0]);
        exp_nwr = 1;
      end
    end
    exp_tr = exp_tr << off;
    exp_done += off;

    Req = 1'b1; Write = wr; Memfunc = fn; Address = ad; StoreData = sd;
    c = 0; act_tr = '0; bad = 0; nwr = 0; txn = 0; in_txn = 1'b0; wcnt = 0;
    seen = 1'b0; err_obs = 1'b0; ld_obs = '0; wr_addr = '0;
    t_addr = '0; t_wdata = '0; t_we = 1'b0;
    if (b2b) begin @(posedge clock); #1; c = 1; end
    while (!seen && c < 64) begin
      @(negedge clock);
      if (Stall !== (c < exp_done)) bad++;
      if (Error && !Done) bad++;
      act_tr[c] = mem_req;
      if (Done) begin
        seen = 1'b1;
        err_obs = Error;
        ld_obs = LoadData;
      end
      cur_w = (txn == 0) ? w1 : w2;
      if (mem_req) begin
        if (mem_addr[1:0] !== 2'b00) bad++;
        if (!in_txn) begin
          in_txn = 1'b1; wcnt = 0;
          t_addr = mem_addr; t_wdata = mem_wdata; t_we = mem_we;
        end else if (mem_addr !== t_addr || mem_wdata !== t_wdata || mem_we !== t_we) begin
          bad++;
        end
        if (wcnt == cur_w) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? $urandom : mem[mem_addr[9:2]];
          if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wr_addr = mem_addr;
            nwr++;
          end
          in_txn = 1'b0;
          txn++;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        in_txn = 1'b0;
      end
      if (!seen) begin @(posedge clock); #1; c++; end
    end
    Req = 1'b0;
    done_c = seen ? c : 999;
    check("done_cycle", 64'(done_c), 64'(exp_done));
    check("error", 64'(err_obs), 64'(exp_err));
    check("loaddata", 64'(ld_obs), 64'(exp_ld));
    check("mem_word", 64'(mem[idx]), 64'(exp_w));
    check("req_trace", act_tr, exp_tr);
    check("stall_stable", 64'(bad), 64'd0);
    check("write_count", 64'(nwr), 64'(exp_nwr));
    if (exp_nwr != 0) check("write_addr", 64'(wr_addr), 64'({ad[31:2], 2'b00}));
    exp_load = exp_ld;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_wr, r_b2b;
    logic [2:0]  r_fn;
    logic [31:0] r_ad;
    int unsigned r_w1, r_w2;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b1; Req = 1'b0; Write = 1'b0; Memfunc = '0; Address = '0; StoreData = '0;
    mem_ack = 1'b0; mem_rdata = '0; exp_load = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_done_err", 64'({Done, Error}), 64'd0);
    check("rst_loaddata", 64'(LoadData), 64'd0);
    check("rst_stall", 64'(Stall), 64'd0);

    // Load BU at 0x103
    mem[8'h40] = 32'hA1B2C3D4;
    tick();
    access(1'b0, 3'(MF_BU), 32'h103, 32'h0, 0, 0, 1'b0);
    check("bu_load_const", 64'(LoadData), 64'h0000_00A1);

    // Store BS at 0x102 via read-modify-write
    mem[8'h40] = 32'h11223344;
    tick();
    access(1'b1, 3'(MF_BS), 32'h102, 32'h0000_00EE, 0, 0, 1'b0);
    check("bs_merge_const", 64'(mem[8'h40]), 64'h11EE_3344);

    // Misaligned half load and illegal WC store
    tick();
    access(1'b0, 3'(MF_HS), 32'h201, $urandom, 0, 0, 1'b0);
    tick();
    access(1'b1, 3'(MF_WC), 32'h40, $urandom, 0, 0, 1'b0);

    // WD store with ack withheld: timeout
    tick();
    access(1'b1, 3'(MF_WD), 32'h40, 32'hCAFE_F00D, 100, 0, 1'b0);

    // Reset during the second wait cycle of a WD load
    tick();
    mem_ack = 1'b0;
    Req = 1'b1; Write = 1'b0; Memfunc = 3'(MF_WD); Address = 32'h80;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    Req = 1'b0;
    @(negedge clock);
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_done", 64'({Done, Error}), 64'd0);
    check("midrst_loaddata", 64'(LoadData), 64'd0);
    check("midrst_mem_addr", 64'(mem_addr), 64'd0);
    reset = 1'b0;
    exp_load = '0;
    tick();
    access(1'b0, 3'(MF_WD), 32'h84, 32'h0, 1, 0, 1'b0);

    // Back-to-back WR store then WL load
    mem[8'hC0] = 32'h12345678;
    tick();
    access(1'b1, 3'(MF_WR), 32'h300, 32'hFFFF_5555, 0, 0, 1'b0);
    access(1'b0, 3'(MF_WL), 32'h302, 32'h0, 0, 0, 1'b1);
    check("wl_load_const", 64'(LoadData), 64'h1234_5555);

    for (int n = 0; n < 40; n++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_fn = 3'($urandom_range(0, 7));
      r_ad = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (r_fn == 3'(MF_HS) || r_fn == 3'(MF_HU)) r_ad[0] = 1'b0;
        if (r_fn == 3'(MF_WD) || r_fn == 3'(MF_WC)) r_ad[1:0] = 2'b00;
      end
      r_w1 = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
      r_w2 = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
      r_b2b = 1'($urandom_range(0, 1));
      if (!r_b2b) tick();
      access(r_wr, r_fn, r_ad, $urandom, r_w1, r_w2, r_b2b);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
